// File: rtl/lzw_pkg.sv
// Shared LZW types: FSM state encoding, dictionary entry layout, code helpers.
package lzw_pkg;

  // Fields of a dictionary entry are carried at this width. Narrower
  // CODE_W/SYM_W values are zero-extended into it, so CODE_W and SYM_W must
  // both be 16 or less.
  localparam int LZW_MAX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HAVE,
    ST_SEARCH,
    ST_EMIT,
    ST_FLUSH
  } lzw_state_e;

  // {prefix code, appended symbol}
  typedef struct packed {
    logic [LZW_MAX_W-1:0] prefix;
    logic [LZW_MAX_W-1:0] sym;
  } lzw_entry_t;

  // Literal code of a symbol: the symbol value itself.
  function automatic logic [LZW_MAX_W-1:0] lit_code(input logic [LZW_MAX_W-1:0] sym);
    return sym;
  endfunction

  // Code of learned entry idx: the learned codes start just past the literals.
  function automatic logic [LZW_MAX_W-1:0] dict_code(input int unsigned sym_w,
                                                     input int unsigned idx);
    return LZW_MAX_W'((32'd1 << sym_w) + idx);
  endfunction

endpackage

// File: rtl/lzw_dict.sv
// LZW dictionary: entry storage, append port, one indexed compare per cycle.
module lzw_dict
  import lzw_pkg::*;
#(
  parameter int SYM_W     = 8,
  parameter int CODE_W    = 12,
  parameter int DICT_SIZE = 256,
  parameter int IDX_W     = 8,
  parameter int CNT_W     = 9
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,     // drop all learned entries
  input  logic             wr_i,      // append key_i at entry[count]
  input  logic [IDX_W-1:0] rd_idx_i,
  input  lzw_entry_t       key_i,     // {prefix, symbol} to look up / append
  output logic             match_o,   // entry[rd_idx_i] equals key_i
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DICT_SIZE);

  logic [CODE_W-1:0] pfx_mem [DICT_SIZE];
  logic [SYM_W-1:0]  sym_mem [DICT_SIZE];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  lzw_entry_t        rd_entry;

  assign full    = (count_q == FULL_CNT);
  assign count_o = count_q;

  // Entry count: clear wins over append; appends stop once full.
  always_comb begin
    count_d = count_q;
    if (clr_i)             count_d = '0;
    else if (wr_i && !full) count_d = count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  // Entry storage; validity is tracked by count, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (wr_i && !full && !clr_i) begin
      pfx_mem[IDX_W'(count_q)] <= key_i.prefix[CODE_W-1:0];
      sym_mem[IDX_W'(count_q)] <= key_i.sym[SYM_W-1:0];
    end
  end

  // Compare the addressed entry, widened to the key layout, against the key.
  always_comb begin
    rd_entry        = '0;
    rd_entry.prefix = LZW_MAX_W'(pfx_mem[rd_idx_i]);
    rd_entry.sym    = LZW_MAX_W'(sym_mem[rd_idx_i]);
    match_o         = (rd_entry == key_i);
  end

endmodule

// File: rtl/lzw_stream_enc.sv
// Streaming LZW encoder: framed symbols in, fixed-width codes out.
module lzw_stream_enc
  import lzw_pkg::*;
#(
  parameter int SYM_W         = 8,
  parameter int CODE_W        = 12,
  parameter int DICT_SIZE     = 256,
  parameter int RESET_ON_FULL = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [SYM_W-1:0]               sym_i,
  input  logic                           sym_valid_i,
  input  logic                           sym_last_i,
  output logic                           sym_ready_o,
  output logic [CODE_W-1:0]              code_o,
  output logic                           code_valid_o,
  output logic                           code_last_o,
  input  logic                           code_ready_i,
  output logic                           busy_o,
  output logic [$clog2(DICT_SIZE+1)-1:0] dict_count_o
);

  localparam int CNT_W = $clog2(DICT_SIZE + 1);
  localparam int IDX_W = (DICT_SIZE > 1) ? $clog2(DICT_SIZE) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DICT_SIZE);

  lzw_state_e        state_q, state_d;
  logic [CODE_W-1:0] prefix_q, prefix_d;
  logic [SYM_W-1:0]  cand_sym_q, cand_sym_d;
  logic              cand_last_q, cand_last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              code_valid_q, code_valid_d;
  logic              code_last_q, code_last_d;

  logic              dict_wr, dict_clr, dict_match;
  logic [CNT_W-1:0]  dict_cnt;
  lzw_entry_t        key;
  logic              sym_acc, code_hs;
  logic [CODE_W-1:0] sym_code, cand_code, hit_code;

  // The lookup key doubles as the append data: a missed {prefix, cand} is
  // exactly what gets learned in EMIT.
  always_comb begin
    key        = '0;
    key.prefix = LZW_MAX_W'(prefix_q);
    key.sym    = LZW_MAX_W'(cand_sym_q);
  end

  lzw_dict #(
    .SYM_W    (SYM_W),
    .CODE_W   (CODE_W),
    .DICT_SIZE(DICT_SIZE),
    .IDX_W    (IDX_W),
    .CNT_W    (CNT_W)
  ) u_dict (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (dict_clr),
    .wr_i    (dict_wr),
    .rd_idx_i(idx_q),
    .key_i   (key),
    .match_o (dict_match),
    .count_o (dict_cnt)
  );

  assign sym_ready_o  = !reset_i && ((state_q == ST_IDLE) || (state_q == ST_HAVE));
  assign sym_acc      = sym_valid_i && sym_ready_o;
  assign code_hs      = code_valid_q && code_ready_i;
  assign code_o       = code_q;
  assign code_valid_o = code_valid_q;
  assign code_last_o  = code_last_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign dict_count_o = dict_cnt;

  assign sym_code  = CODE_W'(lit_code(LZW_MAX_W'(sym_i)));
  assign cand_code = CODE_W'(lit_code(LZW_MAX_W'(cand_sym_q)));
  assign hit_code  = CODE_W'(dict_code(SYM_W, 32'(idx_q)));

  // Next-state logic; code outputs are loaded on entry to EMIT/FLUSH so they
  // stay put under backpressure.
  always_comb begin
    state_d      = state_q;
    prefix_d     = prefix_q;
    cand_sym_d   = cand_sym_q;
    cand_last_d  = cand_last_q;
    idx_d        = idx_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    code_last_d  = code_last_q;
    dict_wr      = 1'b0;
    dict_clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (sym_acc) begin
        prefix_d = sym_code;
        if (sym_last_i) begin
          code_d       = sym_code;
          code_valid_d = 1'b1;
          code_last_d  = 1'b1;
          state_d      = ST_FLUSH;
        end else begin
          state_d = ST_HAVE;
        end
      end
      ST_HAVE: if (sym_acc) begin
        cand_sym_d  = sym_i;
        cand_last_d = sym_last_i;
        idx_d       = '0;
        if (dict_cnt == '0) begin
          code_d       = prefix_q;
          code_valid_d = 1'b1;
          code_last_d  = 1'b0;
          state_d      = ST_EMIT;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (dict_match) begin
          prefix_d = hit_code;
          if (cand_last_q) begin
            code_d       = hit_code;
            code_valid_d = 1'b1;
            code_last_d  = 1'b1;
            state_d      = ST_FLUSH;
          end else begin
            state_d = ST_HAVE;
          end
        end else if (CNT_W'(idx_q) + 1'b1 == dict_cnt) begin
          code_d       = prefix_q;
          code_valid_d = 1'b1;
          code_last_d  = 1'b0;
          state_d      = ST_EMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_EMIT: if (code_hs) begin
        code_valid_d = 1'b0;
        if (dict_cnt != FULL_CNT) dict_wr  = 1'b1;
        else if (RESET_ON_FULL != 0) dict_clr = 1'b1;
        prefix_d = cand_code;
        if (cand_last_q) begin
          code_d       = cand_code;
          code_valid_d = 1'b1;
          code_last_d  = 1'b1;
          state_d      = ST_FLUSH;
        end else begin
          state_d = ST_HAVE;
        end
      end
      ST_FLUSH: if (code_hs) begin
        code_valid_d = 1'b0;
        code_last_d  = 1'b0;
        dict_clr     = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers; reset aborts any frame and drops a pending code.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      prefix_q     <= '0;
      cand_sym_q   <= '0;
      cand_last_q  <= 1'b0;
      idx_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      code_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prefix_q     <= prefix_d;
      cand_sym_q   <= cand_sym_d;
      cand_last_q  <= cand_last_d;
      idx_q        <= idx_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      code_last_q  <= code_last_d;
    end
  end

endmodule
